hilo_muldiv_unit: RTL and testbench

Iterative multi-cycle multiply/divide unit that sits in the execute stage beside the main ALU. It produces the 64-bit {Hi,Lo} value consumed by the HiLo write-back path, and drives a stall request that holds the fetch/decode/execute pipeline registers until the result is ready. It replaces single-cycle 64-bit multiply and adds divide, MADD and MSUB.

---
 rtl/hilo_muldiv_unit.sv | 198 +++++++++++++++++++
 tb/tb_hilo_muldiv_unit.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hilo_muldiv_unit.sv
// Iterative 32-cycle multiply/divide unit producing the {Hi,Lo} result for the
// HiLo write-back path, with MADD/MSUB accumulation and a pipeline stall request.
module hilo_muldiv_unit #(
  parameter int unsigned XLEN = 32
) (
  input  logic                Clk,
  input  logic                Rst,
  input  logic                Start,
  input  logic [2:0]          Op,
  input  logic [XLEN-1:0]     A,
  input  logic [XLEN-1:0]     B,
  input  logic [2*XLEN-1:0]   HiLoIn,
  output logic                Busy,
  output logic                Done,
  output logic [2*XLEN-1:0]   Result,
  output logic                DivByZero,
  output logic                Stall
);

  localparam int unsigned RW = 2 * XLEN;
  localparam int unsigned CW = 6;

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MADD  = 3'b100;
  localparam logic [2:0] OP_MSUB  = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_FIXUP = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [2:0]        op_q, op_d;
  logic [XLEN-1:0]   a_q, a_d;
  logic [XLEN-1:0]   opnd_q, opnd_d;
  logic [RW-1:0]     acc_q, acc_d;
  logic [RW-1:0]     hilo_q, hilo_d;
  logic              neg_q, neg_d;
  logic              aneg_q, aneg_d;
  logic              bzero_q, bzero_d;
  logic [RW-1:0]     result_q, result_d;
  logic              dbz_q, dbz_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  // Operand decode at accept: signedness and magnitudes
  logic              op_valid_c;
  logic              in_signed_c;
  logic              in_div_c;
  logic [XLEN-1:0]   a_mag_c;
  logic [XLEN-1:0]   b_mag_c;

  assign op_valid_c  = (Op <= OP_MSUB);
  assign in_signed_c = (Op == OP_MULT) || (Op == OP_DIV) || (Op == OP_MADD) || (Op == OP_MSUB);
  assign in_div_c    = (Op == OP_DIV) || (Op == OP_DIVU);
  assign a_mag_c     = (in_signed_c && A[XLEN-1]) ? -A : A;
  assign b_mag_c     = (in_signed_c && B[XLEN-1]) ? -B : B;

  // One shift-add multiply step: acc holds {partial product hi, remaining multiplier}
  logic [XLEN:0]     mul_sum_c;
  logic [RW-1:0]     mul_next_c;

  assign mul_sum_c  = {1'b0, acc_q[RW-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
  assign mul_next_c = {mul_sum_c, acc_q[XLEN-1:1]};

  // One restoring divide step: acc holds {partial remainder, dividend/quotient bits}
  logic [XLEN:0]     rem_sh_c;
  logic [XLEN+1:0]   div_diff_c;
  logic [RW-1:0]     div_next_c;

  assign rem_sh_c   = acc_q[RW-1:XLEN-1];
  assign div_diff_c = {1'b0, rem_sh_c} - {2'b00, opnd_q};
  assign div_next_c = div_diff_c[XLEN+1] ? {rem_sh_c[XLEN-1:0], acc_q[XLEN-2:0], 1'b0}
                                         : {div_diff_c[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};

  // Sign correction and accumulation applied in FIXUP
  logic              op_is_div_c;
  logic [RW-1:0]     sprod_c;
  logic [XLEN-1:0]   squot_c;
  logic [XLEN-1:0]   srem_c;
  logic [RW-1:0]     fix_result_c;

  assign op_is_div_c = (op_q == OP_DIV) || (op_q == OP_DIVU);
  assign sprod_c     = neg_q  ? -acc_q : acc_q;
  assign squot_c     = neg_q  ? -acc_q[XLEN-1:0]  : acc_q[XLEN-1:0];
  assign srem_c      = aneg_q ? -acc_q[RW-1:XLEN] : acc_q[RW-1:XLEN];

  always_comb begin
    case (op_q)
      OP_MADD:          fix_result_c = hilo_q + sprod_c;
      OP_MSUB:          fix_result_c = hilo_q - sprod_c;
      OP_DIV, OP_DIVU:  fix_result_c = bzero_q ? {a_q, {XLEN{1'b1}}} : {srem_c, squot_c};
      default:          fix_result_c = sprod_c;
    endcase
  end

  // Next-state and datapath control
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    a_d      = a_q;
    opnd_d   = opnd_q;
    acc_d    = acc_q;
    hilo_d   = hilo_q;
    neg_d    = neg_q;
    aneg_d   = aneg_q;
    bzero_d  = bzero_q;
    result_d = result_q;
    dbz_d    = dbz_q;

    case (state_q)
      S_IDLE: begin
        if (Start && op_valid_c) begin
          state_d = S_RUN;
          cnt_d   = '0;
          op_d    = Op;
          a_d     = A;
          hilo_d  = HiLoIn;
          opnd_d  = in_div_c ? b_mag_c : a_mag_c;
          acc_d   = {XLEN'(0), (in_div_c ? a_mag_c : b_mag_c)};
          neg_d   = in_signed_c && (A[XLEN-1] ^ B[XLEN-1]);
          aneg_d  = in_signed_c && A[XLEN-1];
          bzero_d = (B == '0);
        end
      end
      S_RUN: begin
        cnt_d = cnt_q + CW'(1);
        acc_d = op_is_div_c ? div_next_c : mul_next_c;
        if (cnt_q == CW'(XLEN - 1)) begin
          state_d = S_FIXUP;
        end
      end
      S_FIXUP: begin
        result_d = fix_result_c;
        dbz_d    = op_is_div_c && bzero_q;
        state_d  = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d == S_RUN) || (state_d == S_FIXUP);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      a_q      <= '0;
      opnd_q   <= '0;
      acc_q    <= '0;
      hilo_q   <= '0;
      neg_q    <= 1'b0;
      aneg_q   <= 1'b0;
      bzero_q  <= 1'b0;
      result_q <= '0;
      dbz_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      a_q      <= a_d;
      opnd_q   <= opnd_d;
      acc_q    <= acc_d;
      hilo_q   <= hilo_d;
      neg_q    <= neg_d;
      aneg_q   <= aneg_d;
      bzero_q  <= bzero_d;
      result_q <= result_d;
      dbz_q    <= dbz_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign Busy      = busy_q;
  assign Done      = done_q;
  assign Result    = result_q;
  assign DivByZero = dbz_q;
  // Stall covers the request cycle itself so the pipeline freezes on the accepting edge
  assign Stall     = ((state_q == S_IDLE) && Start) || (state_q == S_RUN) || (state_q == S_FIXUP);

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Scoreboard bench for hilo_muldiv_unit: expected {Hi,Lo}/DivByZero are queued
// when an op is issued and popped when Done is observed.
module tb_hilo_muldiv_unit;

  logic        Clk;
  logic        Rst;
  logic        Start;
  logic [2:0]  Op;
  logic [31:0] A;
  logic [31:0] B;
  logic [63:0] HiLoIn;
  logic        Busy;
  logic        Done;
  logic [63:0] Result;
  logic        DivByZero;
  logic        Stall;

  typedef struct {
    logic [63:0] res;
    logic        dbz;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  hilo_muldiv_unit #(.XLEN(32)) dut (
    .Clk(Clk), .Rst(Rst), .Start(Start), .Op(Op), .A(A), .B(B), .HiLoIn(HiLoIn),
    .Busy(Busy), .Done(Done), .Result(Result), .DivByZero(DivByZero), .Stall(Stall)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference model using native wide arithmetic
  function automatic exp_t model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                 input logic [63:0] hilo);
    exp_t        e;
    longint      sa;
    longint      sb;
    logic [63:0] sp;
    logic [63:0] up;
    int          q;
    int          r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    sp = 64'(sa * sb);
    up = {32'h0, a} * {32'h0, b};
    e.dbz = 1'b0;
    e.res = 64'h0;
    case (op)
      3'd0: e.res = sp;
      3'd1: e.res = up;
      3'd4: e.res = hilo + sp;
      3'd5: e.res = hilo - sp;
      3'd2: begin
        if (b == 32'h0) begin
          e.res = {a, 32'hFFFFFFFF};
          e.dbz = 1'b1;
        end else if (a == 32'h80000000 && b == 32'hFFFFFFFF) begin
          e.res = {32'h0, 32'h80000000};
        end else begin
          q = $signed(a) / $signed(b);
          r = $signed(a) % $signed(b);
          e.res = {32'(r), 32'(q)};
        end
      end
      3'd3: begin
        if (b == 32'h0) begin
          e.res = {a, 32'hFFFFFFFF};
          e.dbz = 1'b1;
        end else begin
          e.res = {a % b, a / b};
        end
      end
      default: e.res = 64'h0;
    endcase
    return e;
  endfunction

  // Issue one op from an IDLE cycle and wait (bounded) for Done
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] hilo, output logic [63:0] res, output logic dbz,
                        output int lat, output int stall_cnt, output logic stall_at_done,
                        output logic timed_out);
    @(negedge Clk);
    Start = 1'b1; Op = op; A = a; B = b; HiLoIn = hilo;
    #1;
    stall_cnt = Stall ? 1 : 0;
    @(posedge Clk);
    #1;
    Start = 1'b0;
    lat = 1;
    timed_out = 1'b1;
    res = 64'hx; dbz = 1'bx; stall_at_done = 1'bx;
    if (Stall) stall_cnt++;
    for (int i = 0; i < 80; i++) begin
      @(posedge Clk);
      #1;
      lat++;
      if (Done) begin
        res = Result; dbz = DivByZero; stall_at_done = Stall;
        timed_out = 1'b0;
        break;
      end
      if (Stall) stall_cnt++;
    end
    @(posedge Clk);
    #1;
  endtask

  task automatic test_reset();
    Rst = 1'b1; Start = 1'b0; Op = 3'd0; A = '0; B = '0; HiLoIn = '0;
    repeat (2) @(posedge Clk);
    #1;
    n_checks++; if (Busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", Busy); end
    n_checks++; if (Done !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%b exp=0", Done); end
    n_checks++; if (DivByZero !== 1'b0) begin n_fail++; $display("FAIL reset_dbz got=%b exp=0", DivByZero); end
    n_checks++; if (Result !== 64'h0) begin n_fail++; $display("FAIL reset_result got=%h exp=0", Result); end
    n_checks++; if (Stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall_lo got=%b exp=0", Stall); end
    Start = 1'b1;
    #1;
    n_checks++; if (Stall !== 1'b1) begin n_fail++; $display("FAIL reset_stall_follows got=%b exp=1", Stall); end
    Start = 1'b0;
    @(negedge Clk);
    Rst = 1'b0;
  endtask

  task automatic test_multu_max();
    logic [63:0] res; logic dbz, sad, to; int lat, sc; exp_t e;
    sb_q.push_back('{res: 64'hFFFFFFFE_00000001, dbz: 1'b0});
    run_op(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'h0, res, dbz, lat, sc, sad, to);
    e = sb_q.pop_front();
    n_checks++; if (to !== 1'b0) begin n_fail++; $display("FAIL multu_timeout got=%b exp=0", to); end
    n_checks++; if (lat != 34) begin n_fail++; $display("FAIL multu_latency got=%0d exp=34", lat); end
    n_checks++; if (res !== e.res) begin n_fail++; $display("FAIL multu_result got=%h exp=%h", res, e.res); end
    n_checks++; if (dbz !== e.dbz) begin n_fail++; $display("FAIL multu_dbz got=%b exp=%b", dbz, e.dbz); end
    n_checks++; if (Busy !== 1'b0 || Done !== 1'b0) begin n_fail++; $display("FAIL multu_idle busy=%b done=%b exp=0/0", Busy, Done); end
    n_checks++; if (Result !== e.res) begin n_fail++; $display("FAIL multu_hold got=%h exp=%h", Result, e.res); end
  endtask

  task automatic test_mult_stall();
    logic [63:0] res; logic dbz, sad, to; int lat, sc; exp_t e;
    sb_q.push_back('{res: 64'hFFFFFFFF_FFFFFFEB, dbz: 1'b0});
    run_op(3'd0, 32'hFFFFFFFD, 32'd7, 64'h0, res, dbz, lat, sc, sad, to);
    e = sb_q.pop_front();
    n_checks++; if (res !== e.res) begin n_fail++; $display("FAIL mult_result got=%h exp=%h", res, e.res); end
    n_checks++; if (sc != 34) begin n_fail++; $display("FAIL mult_stall_cycles got=%0d exp=34", sc); end
    n_checks++; if (sad !== 1'b0) begin n_fail++; $display("FAIL mult_stall_at_done got=%b exp=0", sad); end
  endtask

  task automatic test_div_signed();
    logic [63:0] res; logic dbz, sad, to; int lat, sc; exp_t e;
    sb_q.push_back('{res: {32'hFFFFFFFF, 32'hFFFFFFFD}, dbz: 1'b0});
    sb_q.push_back('{res: {32'h00000000, 32'h80000000}, dbz: 1'b0});
    run_op(3'd2, 32'hFFFFFFF9, 32'd2, 64'h0, res, dbz, lat, sc, sad, to);
    e = sb_q.pop_front();
    n_checks++; if (res !== e.res || dbz !== e.dbz) begin n_fail++; $display("FAIL div_neg7_2 got=%h/%b exp=%h/%b", res, dbz, e.res, e.dbz); end
    run_op(3'd2, 32'h80000000, 32'hFFFFFFFF, 64'h0, res, dbz, lat, sc, sad, to);
    e = sb_q.pop_front();
    n_checks++; if (res !== e.res || dbz !== e.dbz) begin n_fail++; $display("FAIL div_min_neg1 got=%h/%b exp=%h/%b", res, dbz, e.res, e.dbz); end
  endtask

  task automatic test_div_by_zero();
    logic [63:0] res; logic dbz, sad, to; int lat, sc; exp_t e;
    sb_q.push_back('{res: {32'h00000064, 32'hFFFFFFFF}, dbz: 1'b1});
    sb_q.push_back('{res: 64'h6, dbz: 1'b0});
    run_op(3'd3, 32'd100, 32'd0, 64'h0, res, dbz, lat, sc, sad, to);
    e = sb_q.pop_front();
    n_checks++; if (res !== e.res) begin n_fail++; $display("FAIL divz_result got=%h exp=%h", res, e.res); end
    n_checks++; if (dbz !== e.dbz) begin n_fail++; $display("FAIL divz_flag got=%b exp=%b", dbz, e.dbz); end
    n_checks++; if (lat != 34) begin n_fail++; $display("FAIL divz_latency got=%0d exp=34", lat); end
    n_checks++; if (DivByZero !== 1'b1) begin n_fail++; $display("FAIL divz_flag_hold got=%b exp=1", DivByZero); end
    run_op(3'd1, 32'd2, 32'd3, 64'h0, res, dbz, lat, sc, sad, to);
    e = sb_q.pop_front();
    n_checks++; if (res !== e.res || dbz !== e.dbz) begin n_fail++; $display("FAIL divz_then_mul got=%h/%b exp=%h/%b", res, dbz, e.res, e.dbz); end
  endtask

  task automatic test_madd_msub();
    logic [63:0] res; logic dbz, sad, to; int lat, sc; exp_t e;
    sb_q.push_back('{res: 64'h0000000A, dbz: 1'b0});
    sb_q.push_back('{res: 64'h00000016, dbz: 1'b0});
    run_op(3'd4, 32'hFFFFFFFE, 32'd3, 64'h10, res, dbz, lat, sc, sad, to);
    e = sb_q.pop_front();
    n_checks++; if (res !== e.res) begin n_fail++; $display("FAIL madd_result got=%h exp=%h", res, e.res); end
    run_op(3'd5, 32'hFFFFFFFE, 32'd3, 64'h10, res, dbz, lat, sc, sad, to);
    e = sb_q.pop_front();
    n_checks++; if (res !== e.res) begin n_fail++; $display("FAIL msub_result got=%h exp=%h", res, e.res); end
  endtask

  task automatic test_reserved_op();
    logic seen_done;
    @(negedge Clk);
    Start = 1'b1; Op = 3'd6; A = 32'd9; B = 32'd9;
    #1;
    n_checks++; if (Stall !== 1'b1) begin n_fail++; $display("FAIL rsvd_stall got=%b exp=1", Stall); end
    @(posedge Clk);
    #1;
    Start = 1'b0;
    n_checks++; if (Busy !== 1'b0) begin n_fail++; $display("FAIL rsvd_busy got=%b exp=0", Busy); end
    seen_done = 1'b0;
    repeat (40) begin
      @(posedge Clk); #1;
      if (Done) seen_done = 1'b1;
    end
    n_checks++; if (seen_done !== 1'b0) begin n_fail++; $display("FAIL rsvd_done got=%b exp=0", seen_done); end
  endtask

  task automatic test_random();
    logic [63:0] res; logic dbz, sad, to; int lat, sc; exp_t e;
    logic [2:0] op; logic [31:0] a, b; logic [63:0] h;
    for (int i = 0; i < 12; i++) begin
      op = 3'(i % 6);
      a  = $urandom;
      b  = (i % 3 == 0) ? 32'($urandom_range(1, 50)) : $urandom;
      if (i % 4 == 1) b = -b;
      h  = {$urandom, $urandom};
      sb_q.push_back(model(op, a, b, h));
      run_op(op, a, b, h, res, dbz, lat, sc, sad, to);
      e = sb_q.pop_front();
      n_checks++;
      if (to || res !== e.res || dbz !== e.dbz || lat != 34) begin
        n_fail++;
        $display("FAIL rand_%0d op=%0d a=%h b=%h got=%h/%b lat=%0d exp=%h/%b lat=34",
                 i, op, a, b, res, dbz, lat, e.res, e.dbz);
      end
    end
  endtask

  task automatic test_abort();
    logic [63:0] res; logic dbz, sad, to; int lat, sc; exp_t e; logic seen_done;
    @(negedge Clk);
    Start = 1'b1; Op = 3'd1; A = 32'd5; B = 32'd5;
    @(posedge Clk);
    #1;
    Start = 1'b0;
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    Start = 1'b1; Op = 3'd0; A = 32'd7; B = 32'd9;
    @(posedge Clk);
    #1;
    Start = 1'b0;
    n_checks++; if (Busy !== 1'b1 || Done !== 1'b0) begin n_fail++; $display("FAIL abort_extra_start busy=%b done=%b exp=1/0", Busy, Done); end
    n_checks++; if (Result === 64'h0) begin n_fail++; $display("FAIL abort_prior_result got=%h exp=nonzero", Result); end
    repeat (6) @(posedge Clk);
    #1;
    Rst = 1'b1;
    #1;
    n_checks++; if (Result !== 64'h0) begin n_fail++; $display("FAIL abort_result got=%h exp=0", Result); end
    n_checks++; if (Busy !== 1'b0 || Stall !== 1'b0 || Done !== 1'b0) begin n_fail++; $display("FAIL abort_ctrl busy=%b stall=%b done=%b exp=0/0/0", Busy, Stall, Done); end
    @(negedge Clk);
    Rst = 1'b0;
    seen_done = 1'b0;
    repeat (40) begin
      @(posedge Clk); #1;
      if (Done) seen_done = 1'b1;
    end
    n_checks++; if (seen_done !== 1'b0) begin n_fail++; $display("FAIL abort_no_done got=%b exp=0", seen_done); end
    sb_q.push_back('{res: 64'h19, dbz: 1'b0});
    run_op(3'd1, 32'd5, 32'd5, 64'h0, res, dbz, lat, sc, sad, to);
    e = sb_q.pop_front();
    n_checks++; if (res !== e.res || lat != 34) begin n_fail++; $display("FAIL abort_rerun got=%h lat=%0d exp=%h lat=34", res, lat, e.res); end
  endtask

  initial begin
    test_reset();
    test_multu_max();
    test_mult_stall();
    test_div_signed();
    test_div_by_zero();
    test_madd_msub();
    test_reserved_op();
    test_random();
    test_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
